// File: rtl/i2c_log_if.sv
// ==== i2c_log_if : producer-side and logger-side signals of the shared I2C debug logger ====
// Rev 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

interface i2c_log_if #(
    parameter int N_REQ  = 4,
    parameter int PAGE_W = 8,
    parameter int VAL_W  = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*PAGE_W-1:0] req_page;
    logic [N_REQ*VAL_W-1:0]  req_value;
    logic [N_REQ-1:0]        req_ready;
    logic                    log_new;
    logic [PAGE_W-1:0]       log_page;
    logic [VAL_W-1:0]        log_value;
    logic                    log_busy;
    logic [2:0]              grant_id;
    logic [15:0]             drop_cnt;
    logic [15:0]             nobusy_cnt;

    modport slave (
        input  req_valid, req_page, req_value, log_busy,
        output req_ready, log_new, log_page, log_value, grant_id, drop_cnt, nobusy_cnt
    );

    modport master (
        output req_valid, req_page, req_value, log_busy,
        input  req_ready, log_new, log_page, log_value, grant_id, drop_cnt, nobusy_cnt
    );
endinterface

`default_nettype wire

// File: rtl/i2c_log_arbiter.sv
// ==== i2c_log_arbiter : round-robin sharing of one I2C sample logger among N_REQ producers ====
// Rev 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module i2c_log_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PAGE_W    = 8,
    parameter int VAL_W     = 16,
    parameter int BUSY_WAIT = 4
) (
    input  logic       clk,
    input  logic       ext_reset,
    i2c_log_if.slave   bus
);
    localparam int IDXW = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state, w_next;
    logic [N_REQ-1:0]  r_full;
    logic [PAGE_W-1:0] r_page  [N_REQ];
    logic [VAL_W-1:0]  r_value [N_REQ];
    logic [IDXW-1:0]   r_rr, r_sel, w_pick, w_idx;
    logic              w_found, w_timeout;
    logic [3:0]        r_wcnt;
    logic [N_REQ-1:0]  w_free, w_accept, w_drop;
    logic [3:0]        w_ndrop;
    logic [16:0]       w_drop_sum;
    logic              r_log_new;
    logic [PAGE_W-1:0] r_log_page;
    logic [VAL_W-1:0]  r_log_value;
    logic [2:0]        r_grant;
    logic [15:0]       r_drop, r_nobusy;

    // Scan downward so the full slot nearest the RR pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = IDXW'((int'(r_rr) + k) % N_REQ);
            if (r_full[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // A slot being issued counts as empty, so a strobe in that cycle refills it.
    always_comb begin
        w_free   = '0;
        w_accept = '0;
        w_drop   = '0;
        w_ndrop  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_free[i]   = (r_state == S_ISSUE) && (r_sel == IDXW'(i));
            w_accept[i] = bus.req_valid[i] && (!r_full[i] || w_free[i]);
            w_drop[i]   = bus.req_valid[i] && r_full[i] && !w_free[i];
            w_ndrop     = w_ndrop + 4'(w_drop[i]);
        end
        w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (!bus.log_busy && w_found) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.log_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_wcnt == 4'(BUSY_WAIT)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT_DONE: if (!bus.log_busy) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_full      <= '0;
            r_rr        <= '0;
            r_sel       <= '0;
            r_wcnt      <= '0;
            r_log_new   <= 1'b0;
            r_log_page  <= '0;
            r_log_value <= '0;
            r_grant     <= '0;
            r_drop      <= '0;
            r_nobusy    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_page[i]  <= '0;
                r_value[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_full[i]  <= 1'b1;
                    r_page[i]  <= bus.req_page[i*PAGE_W +: PAGE_W];
                    r_value[i] <= bus.req_value[i*VAL_W +: VAL_W];
                end else if (w_free[i]) begin
                    r_full[i]  <= 1'b0;
                end
            end

            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_timeout && r_nobusy != 16'hFFFF) r_nobusy <= r_nobusy + 16'd1;

            if (r_state == S_IDLE && w_next == S_ISSUE) r_sel <= w_pick;

            r_log_new <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_log_new   <= 1'b1;
                r_log_page  <= r_page[r_sel];
                r_log_value <= r_value[r_sel];
                r_grant     <= 3'(r_sel);
                r_rr        <= IDXW'((int'(r_sel) + 1) % N_REQ);
                r_wcnt      <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_wcnt      <= r_wcnt + 4'd1;
            end
        end
    end

    assign bus.req_ready  = ~r_full;
    assign bus.log_new    = r_log_new;
    assign bus.log_page   = r_log_page;
    assign bus.log_value  = r_log_value;
    assign bus.grant_id   = r_grant;
    assign bus.drop_cnt   = r_drop;
    assign bus.nobusy_cnt = r_nobusy;

endmodule

`default_nettype wire
